// File: rtl/bdma_sched_pkg.sv
// Shared types and sizes for the BDMA group scheduler.
package bdma_sched_pkg;

  localparam int NUM_GRP = 2;
  localparam int GRP_W   = 1;
  localparam int CNT_W   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUEUED = 2'd1,
    ISSUED = 2'd2
  } grp_state_e;

endpackage

// File: rtl/nv_nvdla_bdma_grp_sched_if.sv
// Launch channel from the register file and group hand-off channel to the load engine.
interface nv_nvdla_bdma_grp_sched_if import bdma_sched_pkg::*; ();

  logic             grp_launch_vld;
  logic [GRP_W-1:0] grp_launch_id;
  logic             grp_launch_intr;
  logic             grp_launch_intr_ptr;
  logic             grp_launch_rdy;
  logic             csb2ld_vld;
  logic             csb2ld_rdy;
  logic [GRP_W-1:0] csb2ld_grp_id;

  modport master (
    output grp_launch_vld, grp_launch_id, grp_launch_intr, grp_launch_intr_ptr, csb2ld_rdy,
    input  grp_launch_rdy, csb2ld_vld, csb2ld_grp_id
  );

  modport slave (
    input  grp_launch_vld, grp_launch_id, grp_launch_intr, grp_launch_intr_ptr, csb2ld_rdy,
    output grp_launch_rdy, csb2ld_vld, csb2ld_grp_id
  );

endinterface

// File: rtl/nv_nvdla_bdma_grp_fifo.sv
// Two-entry group id FIFO keeping launched groups in launch order.
module nv_nvdla_bdma_grp_fifo import bdma_sched_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [GRP_W-1:0] push_id,
  input  logic             pop,
  output logic [GRP_W-1:0] head_id,
  output logic             empty,
  output logic             full
);

  logic [GRP_W-1:0] mem_q [2];
  logic [GRP_W-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign head_id = mem_q[rd_ptr_q];
  assign empty   = (cnt_q == 2'd0);
  assign full    = (cnt_q == 2'd2);

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/nv_nvdla_bdma_grp_sched.sv
// BDMA group scheduler: orders launched groups, hands them to load one at a time,
// retires them on store done, and raises interrupts, stall counts, idle and clock enables.
module nv_nvdla_bdma_grp_sched import bdma_sched_pkg::*; #(
  parameter int CNT_W = bdma_sched_pkg::CNT_W
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  nv_nvdla_bdma_grp_sched_if.slave grp_if,
  input  logic [NUM_GRP-1:0]    st_grp_done,
  output logic [1:0]            bdma2glb_done_intr_pd,
  output logic [NUM_GRP-1:0]    grp_busy,
  output logic                  done_err,
  input  logic                  ld_stall_inc,
  input  logic                  stall_cnt_clr,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  sched_idle,
  output logic                  sched2gate_slcg_en
);

  grp_state_e       state_q [NUM_GRP];
  grp_state_e       state_d [NUM_GRP];
  logic [NUM_GRP-1:0] intr_q, intr_d;
  logic [NUM_GRP-1:0] ptr_q, ptr_d;
  logic [NUM_GRP-1:0] done_ok;
  logic [1:0]       pd_q, pd_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idle_q, idle_d;
  logic             launch_acc, issue, any_issued, all_idle;
  logic             fifo_empty, fifo_full;
  logic [GRP_W-1:0] head_id;

  // Readiness looks at current state only, so a launch racing its own done is refused.
  assign grp_if.grp_launch_rdy = (state_q[grp_if.grp_launch_id] == IDLE) && !fifo_full;
  assign launch_acc            = grp_if.grp_launch_vld && grp_if.grp_launch_rdy;
  assign issue                 = !fifo_empty && grp_if.csb2ld_rdy;
  assign grp_if.csb2ld_vld     = !fifo_empty;
  assign grp_if.csb2ld_grp_id  = head_id;

  nv_nvdla_bdma_grp_fifo u_fifo (
    .clk     (nvdla_core_clk),
    .rst     (nvdla_core_rst),
    .push    (launch_acc),
    .push_id (grp_if.grp_launch_id),
    .pop     (issue),
    .head_id (head_id),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    any_issued = 1'b0;
    all_idle   = 1'b1;
    for (int g = 0; g < NUM_GRP; g++) begin
      done_ok[g]  = st_grp_done[g] && (state_q[g] == ISSUED);
      grp_busy[g] = (state_q[g] != IDLE);
      any_issued  = any_issued || (state_q[g] == ISSUED);
      all_idle    = all_idle && (state_q[g] == IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    intr_d  = intr_q;
    ptr_d   = ptr_q;
    pd_d    = 2'b00;
    err_d   = err_q;
    for (int g = 0; g < NUM_GRP; g++) begin
      err_d = err_d || (st_grp_done[g] && (state_q[g] != ISSUED));
      pd_d  = pd_d | (2'(done_ok[g] && intr_q[g]) << ptr_q[g]);
      if (done_ok[g]) begin
        state_d[g] = IDLE;
      end else if (issue && (head_id == GRP_W'(g))) begin
        state_d[g] = ISSUED;
      end else if (launch_acc && (grp_if.grp_launch_id == GRP_W'(g))) begin
        state_d[g] = QUEUED;
        intr_d[g]  = grp_if.grp_launch_intr;
        ptr_d[g]   = grp_if.grp_launch_intr_ptr;
      end else begin
        state_d[g] = state_q[g];
      end
    end
  end

  // Clear has priority over a same-cycle stall event; the count sticks at all-ones.
  always_comb begin
    if (stall_cnt_clr) begin
      cnt_d = '0;
    end else if (ld_stall_inc && any_issued && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    idle_d = all_idle && fifo_empty;
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q <= '{default: IDLE};
      intr_q  <= '0;
      ptr_q   <= '0;
      pd_q    <= 2'b00;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      intr_q  <= intr_d;
      ptr_q   <= ptr_d;
      pd_q    <= pd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
    end
  end

  assign bdma2glb_done_intr_pd = pd_q;
  assign done_err              = err_q;
  assign stall_cnt             = cnt_q;
  assign sched_idle            = idle_q;
  assign sched2gate_slcg_en    = !idle_q || grp_if.grp_launch_vld;

endmodule

// File: tb/tb_nv_nvdla_bdma_grp_sched.sv
// Scoreboard bench for the BDMA group scheduler against a queue-based reference model.
module tb_nv_nvdla_bdma_grp_sched;
  import bdma_sched_pkg::*;

  localparam int TCW    = 8;
  localparam int M_IDLE = 0;
  localparam int M_Q    = 1;
  localparam int M_ISS  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     done;
  logic           inc, clr;
  logic [1:0]     pd;
  logic [1:0]     busy;
  logic           err, idle, slcg;
  logic [TCW-1:0] cnt;
  int             cyc = 0;

  nv_nvdla_bdma_grp_sched_if bif();

  nv_nvdla_bdma_grp_sched #(.CNT_W(TCW)) dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rst        (rst),
    .grp_if                (bif.slave),
    .st_grp_done           (done),
    .bdma2glb_done_intr_pd (pd),
    .grp_busy              (busy),
    .done_err              (err),
    .ld_stall_inc          (inc),
    .stall_cnt_clr         (clr),
    .stall_cnt             (cnt),
    .sched_idle            (idle),
    .sched2gate_slcg_en    (slcg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { int c; logic [1:0] v; } intr_t;

  int     mst [2];
  int     ord [$];
  bit     mintr [2];
  bit     mptr [2];
  bit     merr, midle;
  longint mcnt;
  int     exp_issue [$];
  intr_t  exp_intr [$];
  int     checks = 0;
  int     failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mst[i] = M_IDLE; mintr[i] = 1'b0; mptr[i] = 1'b0;
    end
    ord.delete();
    exp_issue.delete();
    merr = 1'b0; midle = 1'b1; mcnt = 0;
  endtask

  // Compare every observable against the model, then advance the model over the coming edge.
  task automatic check_and_model();
    bit         exp_rdy, any_iss, all_idle, nidle;
    logic [1:0] npd;
    int         g;
    exp_rdy = (mst[bif.grp_launch_id] == M_IDLE) && (ord.size() < 2);
    chk("launch_rdy", bif.grp_launch_rdy, exp_rdy);
    chk("csb2ld_vld", bif.csb2ld_vld, ord.size() > 0);
    if (ord.size() > 0) chk("csb2ld_grp_id", bif.csb2ld_grp_id, ord[0]);
    chk("grp_busy", busy, {mst[1] != M_IDLE, mst[0] != M_IDLE});
    chk("done_err", err, merr);
    chk("stall_cnt", cnt, mcnt);
    chk("sched_idle", idle, midle);
    chk("slcg_en", slcg, !midle || bif.grp_launch_vld);
    if (!rst) begin
      any_iss  = (mst[0] == M_ISS) || (mst[1] == M_ISS);
      all_idle = (mst[0] == M_IDLE) && (mst[1] == M_IDLE);
      nidle    = all_idle && (ord.size() == 0);
      npd      = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (done[i]) begin
          if (mst[i] == M_ISS) begin
            mst[i] = M_IDLE;
            if (mintr[i]) npd[mptr[i]] = 1'b1;
          end else begin
            merr = 1'b1;
          end
        end
      end
      if (ord.size() > 0 && bif.csb2ld_rdy) begin
        g = ord.pop_front();
        mst[g] = M_ISS;
      end
      if (bif.grp_launch_vld && exp_rdy) begin
        g = int'(bif.grp_launch_id);
        mst[g] = M_Q; mintr[g] = bif.grp_launch_intr; mptr[g] = bif.grp_launch_intr_ptr;
        ord.push_back(g);
        exp_issue.push_back(g);
      end
      if (clr) mcnt = 0;
      else if (inc && any_iss && mcnt < (64'd1 << TCW) - 1) mcnt = mcnt + 1;
      midle = nidle;
      if (npd != 2'b00) exp_intr.push_back('{c: cyc + 1, v: npd});
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_and_model();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_launch(input bit v, input bit id, input bit in, input bit p);
    bif.grp_launch_vld = v; bif.grp_launch_id = id;
    bif.grp_launch_intr = in; bif.grp_launch_intr_ptr = p;
  endtask

  task automatic pulse_done(input logic [1:0] d);
    done = d; step(); done = 2'b00;
  endtask

  // Monitor: issue order and interrupt pulses are popped from the scoreboard as they appear.
  initial begin
    intr_t e;
    forever begin
      @(negedge clk);
      if (!rst && bif.csb2ld_vld && bif.csb2ld_rdy) begin
        if (exp_issue.size() == 0) begin
          checks++; failures++;
          $display("FAIL issue_unexpected: got id %0d expected no issue", bif.csb2ld_grp_id);
        end else begin
          chk("issue_order", bif.csb2ld_grp_id, exp_issue.pop_front());
        end
      end
      if (pd !== 2'b00) begin
        if (exp_intr.size() == 0) begin
          checks++; failures++;
          $display("FAIL intr_unexpected: got %b expected 00 (cycle %0d)", pd, cyc);
        end else begin
          e = exp_intr.pop_front();
          chk("intr_pd", pd, e.v);
          chk("intr_cycle", cyc, e.c);
        end
      end
    end
  end

  initial begin
    set_launch(1'b0, 1'b0, 1'b0, 1'b0);
    bif.csb2ld_rdy = 1'b0; done = 2'b00; inc = 1'b0; clr = 1'b0;
    model_reset();
    step(3);
    rst = 1'b0;
    step(2);

    // Single launch, issue and interrupt on done.
    bif.csb2ld_rdy = 1'b1;
    set_launch(1'b1, 1'b0, 1'b1, 1'b0); step();
    set_launch(1'b0, 1'b0, 1'b0, 1'b0); step(10);
    pulse_done(2'b01); step(3);

    // Load back-pressure holds the head; issue order follows launch order.
    bif.csb2ld_rdy = 1'b0;
    set_launch(1'b1, 1'b0, 1'b1, 1'b1); step();
    set_launch(1'b1, 1'b1, 1'b1, 1'b0); step();
    set_launch(1'b0, 1'b0, 1'b0, 1'b0); step(5);
    bif.csb2ld_rdy = 1'b1; step(3);
    pulse_done(2'b11); step(2);

    // Same pointer on both groups gives a single-bit pulse.
    set_launch(1'b1, 1'b0, 1'b1, 1'b1); step();
    set_launch(1'b1, 1'b1, 1'b1, 1'b1); step();
    set_launch(1'b0, 1'b0, 1'b0, 1'b0); step(3);
    pulse_done(2'b11); step(2);

    // Relaunch while issued stalls; racing the done is refused, accepted next cycle.
    set_launch(1'b1, 1'b0, 1'b1, 1'b0); step();
    step(4);
    done = 2'b01; step(); done = 2'b00;
    step();
    set_launch(1'b0, 1'b0, 1'b0, 1'b0); step(3);
    pulse_done(2'b01); step(2);

    // Spurious done, then stall counter saturation and clear-wins.
    set_launch(1'b1, 1'b0, 1'b0, 1'b0); step();
    set_launch(1'b0, 1'b0, 1'b0, 1'b0); step(2);
    pulse_done(2'b10); step();
    inc = 1'b1; step((1 << TCW) + 4);
    chk("stall_saturated", cnt, {TCW{1'b1}});
    clr = 1'b1; step();
    clr = 1'b0; inc = 1'b0; step();
    chk("stall_cleared", cnt, {TCW{1'b0}});
    pulse_done(2'b01); step(2);

    // Reset with one group issued and the other queued.
    set_launch(1'b1, 1'b0, 1'b1, 1'b0); step();
    set_launch(1'b0, 1'b0, 1'b0, 1'b0); step();
    bif.csb2ld_rdy = 1'b0;
    set_launch(1'b1, 1'b1, 1'b1, 1'b1); step();
    set_launch(1'b0, 1'b0, 1'b0, 1'b0); step();
    rst = 1'b1; model_reset(); step(3);
    rst = 1'b0; bif.csb2ld_rdy = 1'b1; step(5);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      set_launch($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom), 1'($urandom));
      bif.csb2ld_rdy = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < 2; i++)
        done[i] = (mst[i] == M_ISS) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 60) == 0);
      inc = 1'($urandom);
      clr = ($urandom_range(0, 40) == 0);
      step();
    end

    // Drain outstanding groups.
    set_launch(1'b0, 1'b0, 1'b0, 1'b0);
    inc = 1'b0; clr = 1'b0; bif.csb2ld_rdy = 1'b1;
    for (int n = 0; n < 6; n++) begin
      done = {mst[1] == M_ISS, mst[0] == M_ISS};
      step();
    end
    done = 2'b00; step(4);
    chk("issue_queue_drained", exp_issue.size(), 0);
    chk("intr_queue_drained", exp_intr.size(), 0);
    chk("final_idle", idle, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
